// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parameterised UART receiver.
// The BRK_WAIT state exists only when UART_RX_BREAK_DETECT_EN is defined.
package uart_rx_pkg;

    localparam int unsigned DATA_MIN = 5;

`ifdef UART_RX_BREAK_DETECT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;
`endif

    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int unsigned max_bits);
        logic [3:0] r;
        r = req;
        if (req < 4'(DATA_MIN)) begin
            r = 4'(DATA_MIN);
        end else if (32'(req) > max_bits) begin
            r = 4'(max_bits);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Three-tap majority voter on the raw rx line, shifted once per baud_clock tick.
module uart_rx_filter (
    input  logic clk,
    input  logic reset_n,
    input  logic baud_clock,
    input  logic rx,
    output logic rxf
);

    logic [2:0] taps_q;
    logic [2:0] taps_d;

    always_comb begin
        taps_d = taps_q;
        if (baud_clock) begin
            taps_d = {taps_q[1:0], rx};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taps_q <= 3'b111;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign rxf = (taps_q[0] & taps_q[1]) | (taps_q[0] & taps_q[2]) | (taps_q[1] & taps_q[2]);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime frame format and sticky status flags.
// Optional break detection is compiled in with UART_RX_BREAK_DETECT_EN.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_MAX   = 9,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                baud_clock,
    input  logic                rx,
    input  logic [3:0]          data_bits,
    input  logic                parity_en,
    input  logic                odd_n_even,
    input  logic                two_stop,
    input  logic                read_rx_byte,
    input  logic                clear_errors,
    output logic [DATA_MAX-1:0] rx_data,
    output logic                rx_valid,
    output logic                receive_full,
    output logic                overflow,
    output logic                parity_err,
    output logic                framing_error,
    output logic                break_det,
    output logic                rx_idle
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);

    logic rxf;

    uart_rx_filter u_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud_clock (baud_clock),
        .rx         (rx),
        .rxf        (rxf)
    );

    rx_state_e           state_q, state_d;
    logic [CW-1:0]       tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [3:0]          dbits_q, dbits_d;
    logic [DATA_MAX-1:0] shift_q, shift_d;
    logic [DATA_MAX-1:0] data_q, data_d;
    logic                pen_q, pen_d;
    logic                odd_q, odd_d;
    logic                two_q, two_d;
    logic                stop2_q, stop2_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                valid_q, valid_d;
    logic                sample, complete, perr_set, ferr_set;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                par_bit_q, par_bit_d;
    logic                brk_q, brk_d;
    logic                brk_set;
`endif

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        dbits_d  = dbits_q;
        shift_d  = shift_q;
        data_d   = data_q;
        pen_d    = pen_q;
        odd_d    = odd_q;
        two_d    = two_q;
        stop2_d  = stop2_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        valid_d  = 1'b0;
        complete = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_d = par_bit_q;
        brk_d     = brk_q;
        brk_set   = 1'b0;
`endif
        sample = baud_clock && (tick_q == LAST_TICK);

        case (state_q)
            ST_IDLE: begin
                if (baud_clock && !rxf) begin
                    state_d = ST_START;
                    tick_d  = '0;
                    bit_d   = '0;
                    shift_d = '0;
                    stop2_d = 1'b0;
                    dbits_d = clamp_bits(data_bits, DATA_MAX);
                    pen_d   = parity_en;
                    odd_d   = odd_n_even;
                    two_d   = two_stop;
                end
            end
            ST_START: begin
                if (baud_clock) begin
                    if (tick_q == HALF_TICK) begin
                        tick_d  = '0;
                        state_d = rxf ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (baud_clock) begin
                    tick_d = sample ? '0 : tick_q + 1'b1;
                end
                if (sample) begin
                    for (int unsigned i = 0; i < DATA_MAX; i++) begin
                        if (bit_q == 4'(i)) begin
                            shift_d[i] = rxf;
                        end
                    end
                    if (bit_q == dbits_q - 4'd1) begin
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_clock) begin
                    tick_d = sample ? '0 : tick_q + 1'b1;
                end
                if (sample) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_d = rxf;
`endif
                    perr_set = ((^shift_q) ^ rxf) != odd_q;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_clock) begin
                    tick_d = sample ? '0 : tick_q + 1'b1;
                end
                if (sample) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    // All-zero frame through the first stop sample is a line break.
                    if (!stop2_q && !rxf && shift_q == '0 && !(pen_q && par_bit_q)) begin
                        brk_set  = 1'b1;
                        ferr_set = 1'b1;
                        state_d  = ST_BRK_WAIT;
                    end else
`endif
                    begin
                        ferr_set = !rxf;
                        if (two_q && !stop2_q) begin
                            stop2_d = 1'b1;
                        end else begin
                            complete = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            ST_BRK_WAIT: begin
                if (rxf) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A read in the completion cycle frees the buffer for the new byte.
        if (complete) begin
            valid_d = 1'b1;
            if (!full_q || read_rx_byte) begin
                data_d = shift_q;
                full_d = 1'b1;
                if (read_rx_byte) begin
                    ovf_d = 1'b0;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end else if (read_rx_byte) begin
            full_d = 1'b0;
            ovf_d  = 1'b0;
        end

        if (clear_errors) begin
            perr_d = 1'b0;
            ferr_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_d  = 1'b0;
`endif
        end
        if (perr_set) perr_d = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_set) brk_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            dbits_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            odd_q   <= 1'b0;
            two_q   <= 1'b0;
            stop2_q <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q <= 1'b0;
            brk_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            dbits_q <= dbits_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            pen_q   <= pen_d;
            odd_q   <= odd_d;
            two_q   <= two_d;
            stop2_q <= stop2_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q <= par_bit_d;
            brk_q     <= brk_d;
`endif
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign receive_full  = full_q;
    assign overflow      = ovf_q;
    assign parity_err    = perr_q;
    assign framing_error = ferr_q;
    assign rx_idle       = (state_q == ST_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det     = brk_q;
`else
    assign break_det     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: frame-level model plus directed frames.
module tb_uart_rx_param;

    localparam int unsigned DMAX = 9;
    localparam int unsigned OS   = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            baud_clock = 1'b0;
    logic            rx = 1'b1;
    logic [3:0]      data_bits = 4'd8;
    logic            parity_en = 1'b0;
    logic            odd_n_even = 1'b0;
    logic            two_stop = 1'b0;
    logic            read_rx_byte = 1'b0;
    logic            clear_errors = 1'b0;
    logic [DMAX-1:0] rx_data;
    logic            rx_valid, receive_full, overflow, parity_err;
    logic            framing_error, break_det, rx_idle;

    uart_rx_param #(.DATA_MAX(DMAX), .OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .baud_clock    (baud_clock),
        .rx            (rx),
        .data_bits     (data_bits),
        .parity_en     (parity_en),
        .odd_n_even    (odd_n_even),
        .two_stop      (two_stop),
        .read_rx_byte  (read_rx_byte),
        .clear_errors  (clear_errors),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .receive_full  (receive_full),
        .overflow      (overflow),
        .parity_err    (parity_err),
        .framing_error (framing_error),
        .break_det     (break_det),
        .rx_idle       (rx_idle)
    );

    always #5 clk = ~clk;

    initial begin : baud_gen
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            baud_clock = (c % 3 == 0);
        end
    end

    int tests = 0;
    int fails = 0;
    int nvalid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Frame-level model: expected outcome of each frame in flight, plus buffer/flag state.
    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;
    exp_t exp_q[$];

    logic [8:0] m_data = '0;
    logic m_full = 1'b0, m_ovf = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_brk = 1'b0;
    logic rd, clr, rst;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            rd  = read_rx_byte;
            clr = clear_errors;
            rst = reset_n;
            #1;
            if (!rst) begin
                m_data = '0; m_full = 0; m_ovf = 0; m_perr = 0; m_ferr = 0; m_brk = 0;
                exp_q.delete();
                chk("rst_valid", rx_valid, 0);
                chk("rst_idle", rx_idle, 1);
                chk("rst_flags", {parity_err, framing_error, break_det}, 0);
            end else begin
                if (clr) begin
                    m_perr = 0; m_ferr = 0; m_brk = 0;
                end
                if (rx_valid) begin
                    nvalid++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rx_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (!m_full || rd) begin
                            m_data = e.data;
                            m_full = 1;
                            if (rd) m_ovf = 0;
                        end else begin
                            m_ovf = 1;
                        end
                        m_perr = m_perr | e.perr;
                        m_ferr = m_ferr | e.ferr;
                        chk("frame_parity_err", parity_err, m_perr);
                        chk("frame_framing_err", framing_error, m_ferr);
                    end
                end else if (rd) begin
                    m_full = 0;
                    m_ovf  = 0;
                end
                if (rx_idle && exp_q.size() == 0) begin
                    chk("idle_parity_err", parity_err, m_perr);
                    chk("idle_framing_err", framing_error, m_ferr);
                end
                chk("break_det", break_det, m_brk);
            end
            chk("rx_data", rx_data, m_data);
            chk("receive_full", receive_full, m_full);
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (!baud_clock);
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (OS) wait_tick();
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) read_rx_byte = 1; else clear_errors = 1;
        @(negedge clk);
        read_rx_byte = 0;
        clear_errors = 0;
    endtask

    task automatic send_frame(input logic [8:0] d, input int db_in, input bit pen, input bit odd,
                              input bit two, input bit bad_par, input bit bad_stop);
        int nb;
        logic [8:0] m;
        logic p;
        exp_t e;
        nb = (db_in < 5) ? 5 : (db_in > int'(DMAX)) ? int'(DMAX) : db_in;
        m = d & 9'((1 << nb) - 1);
        p = (^m) ^ odd ^ bad_par;
        wait_tick();
        data_bits = 4'(db_in);
        parity_en = pen;
        odd_n_even = odd;
        two_stop = two;
        e.data = m;
        e.perr = pen & bad_par;
        e.ferr = bad_stop;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(m[i]);
        if (pen) drive_bit(p);
        drive_bit(!bad_stop);
        if (two) drive_bit(1'b1);
        rx = 1'b1;
        repeat (24) wait_tick();
        chk("frame_consumed", exp_q.size(), 0);
    endtask

    initial begin : stim
        int v0;
        repeat (5) @(negedge clk);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_full", receive_full, 0);
        chk("reset_idle", rx_idle, 1);
        reset_n = 1;
        repeat (10) wait_tick();

        // 8N1 0xA5
        v0 = nvalid;
        send_frame(9'h0A5, 8, 0, 0, 0, 0, 0);
        chk("a5_data", rx_data, 9'h0A5);
        chk("a5_one_valid", nvalid - v0, 1);
        chk("a5_full", receive_full, 1);
        chk("a5_errs", {parity_err, framing_error, overflow}, 0);
        pulse(0);
        chk("a5_read_full", receive_full, 0);

        // 9E1 0x1FF with wrong parity bit
        send_frame(9'h1FF, 9, 1, 0, 0, 1, 0);
        chk("p9_perr", parity_err, 1);
        chk("p9_data", rx_data, 9'h1FF);
        pulse(1);
        chk("p9_clear", parity_err, 0);
        pulse(0);

        // two frames without a read
        send_frame(9'h011, 8, 0, 0, 0, 0, 0);
        send_frame(9'h022, 8, 0, 0, 0, 0, 0);
        chk("ovf_data", rx_data, 9'h011);
        chk("ovf_set", overflow, 1);
        pulse(0);
        chk("ovf_read_ovf", overflow, 0);
        chk("ovf_read_full", receive_full, 0);

        // 7O2 with good parity
        send_frame(9'h05A, 7, 1, 1, 1, 0, 0);
        chk("o72_data", rx_data, 9'h05A);
        chk("o72_perr", parity_err, 0);
        pulse(0);

        // data_bits clamp: 3 -> 5 bits, 15 -> 9 bits
        send_frame(9'h0F3, 3, 0, 0, 0, 0, 0);
        chk("clamp_lo_data", rx_data, 9'h013);
        pulse(0);
        send_frame(9'h1AB, 15, 0, 0, 0, 0, 0);
        chk("clamp_hi_data", rx_data, 9'h1AB);
        pulse(0);

        // framing error on a non-zero frame
        send_frame(9'h03C, 8, 0, 0, 0, 0, 1);
        chk("ferr_set", framing_error, 1);
        chk("ferr_data", rx_data, 9'h03C);
        pulse(1);
        chk("ferr_clear", framing_error, 0);
        pulse(0);

`ifndef UART_RX_BREAK_DETECT_EN
        send_frame(9'h000, 8, 0, 0, 0, 0, 1);
        chk("zero_ferr", framing_error, 1);
        chk("zero_full", receive_full, 1);
        pulse(1);
        pulse(0);
`endif

        // 4-tick glitch: false start, then 1-tick glitch: rejected
        v0 = nvalid;
        wait_tick();
        rx = 0;
        repeat (4) wait_tick();
        chk("glitch4_started", rx_idle, 0);
        rx = 1;
        repeat (20) wait_tick();
        chk("glitch4_idle", rx_idle, 1);
        rx = 0;
        wait_tick();
        rx = 1;
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            chk("glitch1_idle", rx_idle, 1);
        end
        chk("glitch_no_valid", nvalid - v0, 0);

`ifdef UART_RX_BREAK_DETECT_EN
        v0 = nvalid;
        data_bits = 8; parity_en = 0; two_stop = 0;
        wait_tick();
        rx = 0;
        repeat (20 * OS) wait_tick();
        chk("brk_det", break_det, 1);
        chk("brk_ferr", framing_error, 1);
        chk("brk_not_idle", rx_idle, 0);
        m_brk = 1;
        m_ferr = 1;
        rx = 1;
        begin
            int n;
            n = 0;
            while (!rx_idle && n < 20) begin
                wait_tick();
                n++;
            end
        end
        chk("brk_idle_after_high", rx_idle, 1);
        chk("brk_no_valid", nvalid - v0, 0);
        pulse(1);
`endif

        // reset during bit 4 of 0x3C
        v0 = nvalid;
        data_bits = 8; parity_en = 0; two_stop = 0;
        wait_tick();
        rx = 0;
        repeat (OS) wait_tick();
        rx = 0; repeat (OS) wait_tick();
        rx = 0; repeat (OS) wait_tick();
        rx = 1; repeat (OS) wait_tick();
        rx = 1; repeat (OS) wait_tick();
        rx = 1; repeat (11) wait_tick();
        reset_n = 0;
        @(negedge clk);
        chk("abort_data", rx_data, 0);
        chk("abort_idle", rx_idle, 1);
        chk("abort_full", receive_full, 0);
        rx = 1;
        repeat (6) wait_tick();
        reset_n = 1;
        repeat (40) wait_tick();
        chk("abort_no_valid", nvalid - v0, 0);
        send_frame(9'h055, 8, 0, 0, 0, 0, 0);
        chk("post_reset_data", rx_data, 9'h055);
        chk("post_reset_errs", {parity_err, framing_error, overflow}, 0);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
